// File: rtl/wadd_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package wadd_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla8_slice.sv
// Combinational 8-bit carry-lookahead adder slice.
// With WADD_OVF_EN defined it also exposes c7, the carry into the top bit.
module cla8_slice
  import wadd_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
`ifdef WADD_OVF_EN
  ,
  output logic               c7
`endif
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;
  logic               run_p;

  // Every carry is a flat sum of generate terms, each gated by the propagate
  // product of the bits above it, so no carry waits on its lower neighbour.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    c[0]  = cin;
    run_p = 1'b1;
    for (int i = 1; i <= SLICE_W; i++) begin
      run_p = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i]  = c[i] | (g[j] & run_p);
        run_p = run_p & p[j];
      end
      c[i] = c[i] | (run_p & cin);
    end
    sum  = p ^ c[SLICE_W-1:0];
    cout = c[SLICE_W];
  end

`ifdef WADD_OVF_EN
  assign c7 = c[SLICE_W-1];
`endif

endmodule

// File: rtl/wide_add_sequencer.sv
// Byte-serial wide adder: one 8-bit CLA slice reused LSB byte first, carry held in a flop.
// Define WADD_OVF_EN to add the signed-overflow output ovf.
module wide_add_sequencer
  import wadd_pkg::*;
#(
  parameter int NBYTES = 4
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLICE_W*NBYTES-1:0] a,
  input  logic [SLICE_W*NBYTES-1:0] b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SLICE_W*NBYTES-1:0] sum,
  output logic                    cout,
  output logic                    busy
`ifdef WADD_OVF_EN
  ,
  output logic                    ovf
`endif
);

  localparam int DW    = SLICE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]     a_q, a_d;
  logic [DW-1:0]     b_q, b_d;
  logic [DW-1:0]     sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[SLICE_W*idx_q +: SLICE_W];
  assign slice_b = b_q[SLICE_W*idx_q +: SLICE_W];

`ifdef WADD_OVF_EN
  logic ovf_q, ovf_d;
  logic slice_c7;

  cla8_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c7   (slice_c7)
  );

  assign ovf = ovf_q;
`else
  cla8_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef WADD_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        // idx parks on the last byte instead of wrapping
        if (idx_q == IDX_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
`ifdef WADD_OVF_EN
          ovf_d       = slice_c7 ^ slice_cout;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef WADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef WADD_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule
